// File: rtl/fifo_rd_ser_if.sv
// Signal bundle between fifo_rd_ser, the FIFO read port it drains and the bit-serial sink.
interface fifo_rd_ser_if #(
  parameter int n = 4
);
  logic         empty;
  logic [n-1:0] data;
  logic         cke_o;
  logic         cke;
  logic         sdo;
  logic         sdo_stb;
  logic         frame;
  logic         busy;

  modport master (
    input  empty, data, cke,
    output cke_o, sdo, sdo_stb, frame, busy
  );

  modport slave (
    output empty, data, cke,
    input  cke_o, sdo, sdo_stb, frame, busy
  );
endinterface

// File: rtl/fifo_rd_ser.sv
// Pops words from a FIFO one at a time and shifts them out on sdo with a per-bit strobe,
// paced by the cke enable and a divide-by-div down-counter.
module fifo_rd_ser #(
  parameter int n         = 4,
  parameter int div       = 1,
  parameter bit msb_first = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  fifo_rd_ser_if.master bus
);
  // state    | meaning
  // st_idle  | waiting for a non-empty FIFO
  // st_pop   | cke_o high for one cycle, FIFO advances
  // st_load  | FIFO data valid, captured into the shift register
  // st_shift | serialising the word, one bit per divider tick
  localparam int bw = $clog2(n);
  localparam int dw = (div > 1) ? $clog2(div) : 1;
  localparam logic [bw-1:0] bit_last = bw'(n - 1);
  localparam logic [dw-1:0] div_last = dw'(div - 1);

  typedef enum logic [1:0] {st_idle, st_pop, st_load, st_shift} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [n-1:0]  sreg;
  logic [n-1:0]  sreg_shifted;
  logic [bw-1:0] bcnt;
  logic [dw-1:0] dcnt;
  logic          tick;
  logic          out_bit;

  assign tick         = (state == st_shift) && bus.cke && (dcnt == '0);
  assign out_bit      = msb_first ? sreg[n-1] : sreg[0];
  assign sreg_shifted = msb_first ? {sreg[n-2:0], 1'b0} : {1'b0, sreg[n-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= st_idle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle:  if (!bus.empty) state_nxt = st_pop;
      st_pop:   state_nxt = st_load;
      st_load:  state_nxt = st_shift;
      st_shift: if (tick && (bcnt == '0)) state_nxt = st_idle;
      default:  state_nxt = st_idle;
    endcase
  end

  always_comb begin
    bus.cke_o   = 1'b0;
    bus.sdo     = 1'b0;
    bus.sdo_stb = 1'b0;
    bus.frame   = 1'b0;
    bus.busy    = (state != st_idle);
    case (state)
      st_pop: bus.cke_o = 1'b1;
      st_shift: begin
        bus.frame   = 1'b1;
        bus.sdo     = out_bit;
        bus.sdo_stb = tick;
      end
      default: ;
    endcase
  end

  // With cke low nothing below moves, so sdo holds its bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      bcnt <= '0;
      dcnt <= '0;
    end else if (state == st_load) begin
      sreg <= bus.data;
      bcnt <= bit_last;
      dcnt <= div_last;
    end else if (tick) begin
      sreg <= sreg_shifted;
      dcnt <= div_last;
      if (bcnt != '0) bcnt <= bcnt - bw'(1);
    end else if ((state == st_shift) && bus.cke) begin
      dcnt <= dcnt - dw'(1);
    end
  end
endmodule

// File: tb/tb_fifo_rd_ser.sv
// Scoreboard bench for fifo_rd_ser: three instances (div/bit-order variants) fed by FIFO models,
// checked every cycle against a pop/serialise timeline model.
`timescale 1ns/1ps
module tb_fifo_rd_ser;
  localparam int n  = 4;
  localparam int ni = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_ser_if #(.n(n)) bus0 ();
  fifo_rd_ser_if #(.n(n)) bus1 ();
  fifo_rd_ser_if #(.n(n)) bus2 ();

  fifo_rd_ser #(.n(n), .div(1), .msb_first(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fifo_rd_ser #(.n(n), .div(3), .msb_first(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fifo_rd_ser #(.n(n), .div(1), .msb_first(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic int div_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic bit msb_of(input int k);
    return (k != 2);
  endfunction

  // FIFO models
  logic [n-1:0] mem [ni][64];
  int           wr_ptr [ni];
  int           rd_ptr [ni];
  logic [n-1:0] data_r [ni];
  logic         cke_v [ni];
  int           cke_mode [ni];

  logic o_cko [ni], o_sdo [ni], o_stb [ni], o_frame [ni], o_busy [ni];

  assign bus0.empty = (rd_ptr[0] == wr_ptr[0]);
  assign bus0.data  = data_r[0];
  assign bus0.cke   = cke_v[0];
  assign bus1.empty = (rd_ptr[1] == wr_ptr[1]);
  assign bus1.data  = data_r[1];
  assign bus1.cke   = cke_v[1];
  assign bus2.empty = (rd_ptr[2] == wr_ptr[2]);
  assign bus2.data  = data_r[2];
  assign bus2.cke   = cke_v[2];

  assign o_cko[0] = bus0.cke_o;  assign o_sdo[0] = bus0.sdo;  assign o_stb[0] = bus0.sdo_stb;
  assign o_frame[0] = bus0.frame; assign o_busy[0] = bus0.busy;
  assign o_cko[1] = bus1.cke_o;  assign o_sdo[1] = bus1.sdo;  assign o_stb[1] = bus1.sdo_stb;
  assign o_frame[1] = bus1.frame; assign o_busy[1] = bus1.busy;
  assign o_cko[2] = bus2.cke_o;  assign o_sdo[2] = bus2.sdo;  assign o_stb[2] = bus2.sdo_stb;
  assign o_frame[2] = bus2.frame; assign o_busy[2] = bus2.busy;

  always @(posedge clk) begin
    for (int k = 0; k < ni; k++)
      if (o_cko[k] === 1'b1 && rd_ptr[k] < wr_ptr[k]) begin
        data_r[k] <= mem[k][rd_ptr[k]];
        rd_ptr[k] <= rd_ptr[k] + 1;
      end
  end

  // Scoreboard of expected serial bits, per instance, in wire order
  bit exp_bits [ni][1024];
  int exp_wr [ni];
  int exp_rd [ni];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int k, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d t=%0t got %b want %b", name, k, $time, act, exp);
  endtask

  task automatic step(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input int k, input logic [n-1:0] w);
    mem[k][wr_ptr[k]] = w;
    wr_ptr[k]++;
    for (int i = 0; i < n; i++) begin
      exp_bits[k][exp_wr[k]] = msb_of(k) ? w[n-1-i] : w[i];
      exp_wr[k]++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < ni; k++)
        case (cke_mode[k])
          0:       cke_v[k] = 1'b1;
          1:       cke_v[k] = ~cke_v[k];
          default: cke_v[k] = ($urandom_range(0, 3) != 0);
        endcase
    end
  end

  // Timeline model: a pop follows any idle cycle that saw a word, then one load cycle,
  // then a strobe every div-th enabled cycle until n bits have gone out.
  int phase [ni];
  bit pop_due [ni];
  int en_cnt [ni];
  int left [ni];

  initial begin
    logic e_cko, e_busy, e_frame, e_stb;
    for (int k = 0; k < ni; k++) begin
      phase[k] = -1;
      pop_due[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < ni; k++) begin
        if (rst) begin
          check("rst_cke_o", k, o_cko[k], 1'b0);
          check("rst_busy", k, o_busy[k], 1'b0);
          check("rst_frame", k, o_frame[k], 1'b0);
          check("rst_stb", k, o_stb[k], 1'b0);
          check("rst_sdo", k, o_sdo[k], 1'b0);
          if (phase[k] >= 0) exp_rd[k] += left[k];
          phase[k] = -1;
          pop_due[k] = 1'b0;
        end else begin
          e_cko = 1'b0; e_busy = 1'b0; e_frame = 1'b0; e_stb = 1'b0;
          if (pop_due[k]) begin
            e_cko = 1'b1; e_busy = 1'b1;
            pop_due[k] = 1'b0;
            phase[k] = 0; left[k] = n; en_cnt[k] = 0;
          end else if (phase[k] == 0) begin
            e_busy = 1'b1;
            phase[k] = 1;
          end else if (phase[k] == 1) begin
            e_busy = 1'b1; e_frame = 1'b1;
            if (cke_v[k]) begin
              en_cnt[k]++;
              if (en_cnt[k] == div_of(k)) begin
                e_stb = 1'b1;
                en_cnt[k] = 0;
              end
            end
          end else begin
            pop_due[k] = (rd_ptr[k] != wr_ptr[k]);
          end
          check("cke_o", k, o_cko[k], e_cko);
          check("busy", k, o_busy[k], e_busy);
          check("frame", k, o_frame[k], e_frame);
          check("sdo_stb", k, o_stb[k], e_stb);
          if (e_frame) begin
            if (exp_rd[k] < exp_wr[k]) check("sdo", k, o_sdo[k], exp_bits[k][exp_rd[k]]);
            else check("sb_underflow", k, 1'b1, 1'b0);
            if (e_stb) begin
              exp_rd[k]++;
              left[k]--;
              if (left[k] == 0) phase[k] = -1;
            end
          end else begin
            check("sdo_idle", k, o_sdo[k], 1'b0);
          end
        end
      end
    end
  end

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step(1);
      done = 1'b1;
      for (int k = 0; k < ni; k++)
        if (rd_ptr[k] != wr_ptr[k] || phase[k] >= 0 || pop_due[k] || exp_rd[k] != exp_wr[k])
          done = 1'b0;
    end
    check("drain", 0, done, 1'b1);
  endtask

  initial begin
    bit got;
    logic [n-1:0] w;
    for (int k = 0; k < ni; k++) begin
      cke_mode[k] = 0;
      cke_v[k] = 1'b1;
    end
    #2 rst = 1'b1;
    step(3);
    rst = 1'b0;

    step(50);

    push_word(0, 4'b1010);
    drain(40);

    push_word(0, 4'b0011);
    push_word(0, 4'b1100);
    drain(60);

    push_word(1, 4'b1001);
    drain(60);

    cke_mode[2] = 1;
    push_word(2, 4'b0001);
    drain(60);
    cke_mode[2] = 0;

    push_word(0, 4'b1111);
    push_word(0, 4'b0110);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = o_stb[0];
    end
    check("rst_setup", 0, got, 1'b1);
    step(1);
    rst = 1'b1;
    #1;
    check("async_cke_o", 0, o_cko[0], 1'b0);
    check("async_busy", 0, o_busy[0], 1'b0);
    check("async_frame", 0, o_frame[0], 1'b0);
    check("async_stb", 0, o_stb[0], 1'b0);
    check("async_sdo", 0, o_sdo[0], 1'b0);
    step(1);
    rst = 1'b0;
    drain(60);

    for (int k = 0; k < ni; k++) cke_mode[k] = 2;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < ni; k++)
        if ($urandom_range(0, 1) == 1) begin
          w = n'($urandom_range(0, 15));
          push_word(k, w);
        end
      step($urandom_range(1, 12));
    end
    drain(800);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
